// File: rtl/store_size_merge.sv
// Store-path sequencer in front of data memory: word stores write straight through,
// half/byte stores read the target word, splice in the low bits, and write it back.
module store_size_merge #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  store_size_control,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_data_out,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_data_in,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         size_q;
    logic [15:0]        data_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_data_in_q;
    logic               mem_wr_q;
    logic               busy_q;
    logic               done_q;
    logic [31:0]        merged_d;

    // Sub-word values always live in the low bits of the addressed word.
    function automatic logic [31:0] merge_word(input logic [1:0]  size,
                                               input logic [31:0] mem_word,
                                               input logic [15:0] data);
        logic [31:0] result;
        case (size)
            2'd2:    result = {mem_word[31:16], data};
            2'd3:    result = {mem_word[31:8], data[7:0]};
            default: result = mem_word;
        endcase
        return result;
    endfunction

    assign merged_d = merge_word(size_q, mem_data_out, data_q);

    // Sequencer: outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            size_q        <= 2'd0;
            data_q        <= 16'h0000;
            mem_addr_q    <= 32'h0000_0000;
            mem_data_in_q <= 32'h0000_0000;
            mem_wr_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        size_q     <= store_size_control;
                        data_q     <= store_data[15:0];
                        mem_addr_q <= address;
                        busy_q     <= 1'b1;
                        case (store_size_control)
                            2'd1: begin
                                state_q       <= S_WRITE;
                                mem_wr_q      <= 1'b1;
                                mem_data_in_q <= store_data;
                            end
                            2'd2, 2'd3: begin
                                state_q <= S_READ;
                                cnt_q   <= CNT_INIT;
                            end
                            default: begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_q       <= S_WRITE;
                        mem_wr_q      <= 1'b1;
                        mem_data_in_q <= merged_d;
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wr      = mem_wr_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_store_size_merge.sv
// Bench for store_size_merge: two instances (read latency 1 and 3) share stimulus,
// each backed by its own memory, checked against a word-array reference model.
module tb_store_size_merge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  size;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        fill_en;

    logic [31:0] mem_addr_a, mem_data_in_a, mem_data_out_a;
    logic        mem_wr_a, busy_a, done_a;
    logic [31:0] mem_addr_b, mem_data_in_b, mem_data_out_b;
    logic        mem_wr_b, busy_b, done_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] ref_m [0:255];
    logic [31:0] pipe1_b, pipe2_b;

    int n_checks;
    int n_pass;

    always #5 clk = ~clk;

    store_size_merge #(.READ_LATENCY(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .store_size_control(size),
        .address(address), .store_data(store_data), .mem_data_out(mem_data_out_a),
        .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mem_data_in(mem_data_in_a),
        .busy(busy_a), .done(done_a)
    );

    store_size_merge #(.READ_LATENCY(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .store_size_control(size),
        .address(address), .store_data(store_data), .mem_data_out(mem_data_out_b),
        .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_data_in(mem_data_in_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [31:0] init_word(input int idx);
        return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Memory a answers combinationally; memory b is a two-stage pipeline (3 cycles total).
    assign mem_data_out_a = mem_a[mem_addr_a[7:0]];
    assign mem_data_out_b = pipe2_b;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (mem_wr_a) mem_a[mem_addr_a[7:0]] <= mem_data_in_a;
            if (mem_wr_b) mem_b[mem_addr_b[7:0]] <= mem_data_in_b;
        end
        pipe1_b <= mem_b[mem_addr_b[7:0]];
        pipe2_b <= pipe1_b;
    end

    task automatic test_reset();
        logic [31:0] o_addr, o_din;
        logic        o_wr, o_busy, o_done;
        @(posedge clk); #1;
        fill_en = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            o_addr = j ? mem_addr_b : mem_addr_a;
            o_din  = j ? mem_data_in_b : mem_data_in_a;
            o_wr   = j ? mem_wr_b : mem_wr_a;
            o_busy = j ? busy_b : busy_a;
            o_done = j ? done_b : done_a;
            n_checks++;
            if ({o_addr, o_din, o_wr, o_busy, o_done} !== 67'd0)
                $display("FAIL reset_outputs dut%0d: got addr=%h din=%h wr=%b busy=%b done=%b expected all 0",
                         j, o_addr, o_din, o_wr, o_busy, o_done);
            else n_pass++;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            o_busy = j ? busy_b : busy_a;
            o_done = j ? done_b : done_a;
            o_wr   = j ? mem_wr_b : mem_wr_a;
            n_checks++;
            if ({o_wr, o_busy, o_done} !== 3'b000)
                $display("FAIL idle_after_reset dut%0d: got wr/busy/done=%b expected 000", j, {o_wr, o_busy, o_done});
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    // Issues one request and checks every cycle of both instances until both are idle again.
    task automatic run_request(input logic [1:0] sz, input logic [31:0] adr,
                               input logic [31:0] dat, input string tag);
        logic [31:0] old_word, exp_word, o_addr, o_din;
        logic        o_wr, o_busy, o_done, e_wr, e_busy, e_done;
        int          wr_k [2];
        int          dn_k [2];
        int          lat;
        int          last;
        old_word = ref_m[adr[7:0]];
        case (sz)
            2'd1:    exp_word = dat;
            2'd2:    exp_word = {old_word[31:16], dat[15:0]};
            2'd3:    exp_word = {old_word[31:8], dat[7:0]};
            default: exp_word = old_word;
        endcase
        for (int j = 0; j < 2; j++) begin
            lat     = (j == 0) ? 1 : 3;
            wr_k[j] = (sz == 2'd1) ? 1 : (sz == 2'd0) ? 0 : lat + 1;
            dn_k[j] = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : lat + 2;
        end
        last = dn_k[1] + 1;
        size       = sz;
        address    = adr;
        store_data = dat;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        address    = $urandom;
        store_data = $urandom;
        size       = 2'($urandom);
        if (sz != 2'd0) ref_m[adr[7:0]] = exp_word;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                o_addr = j ? mem_addr_b : mem_addr_a;
                o_din  = j ? mem_data_in_b : mem_data_in_a;
                o_wr   = j ? mem_wr_b : mem_wr_a;
                o_busy = j ? busy_b : busy_a;
                o_done = j ? done_b : done_a;
                e_wr   = (k == wr_k[j]);
                e_done = (k == dn_k[j]);
                e_busy = (k <= dn_k[j]);
                n_checks++;
                if (o_wr !== e_wr)
                    $display("FAIL %s_mem_wr dut%0d cycle %0d: got %b expected %b", tag, j, k, o_wr, e_wr);
                else n_pass++;
                n_checks++;
                if (o_done !== e_done)
                    $display("FAIL %s_done dut%0d cycle %0d: got %b expected %b", tag, j, k, o_done, e_done);
                else n_pass++;
                n_checks++;
                if (o_busy !== e_busy)
                    $display("FAIL %s_busy dut%0d cycle %0d: got %b expected %b", tag, j, k, o_busy, e_busy);
                else n_pass++;
                n_checks++;
                if (o_addr !== adr)
                    $display("FAIL %s_mem_addr dut%0d cycle %0d: got %h expected %h", tag, j, k, o_addr, adr);
                else n_pass++;
                if (e_wr) begin
                    n_checks++;
                    if (o_din !== exp_word)
                        $display("FAIL %s_mem_data_in dut%0d cycle %0d: got %h expected %h", tag, j, k, o_din, exp_word);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_word();
        run_request(2'd1, 32'h0000_0010, 32'hDEAD_BEEF, "word");
    endtask

    task automatic test_byte();
        run_request(2'd1, 32'h0000_0020, 32'h1122_3344, "byte_setup");
        run_request(2'd3, 32'h0000_0020, 32'hFFFF_FFAB, "byte");
    endtask

    task automatic test_half();
        run_request(2'd1, 32'h0000_0030, 32'hCAFE_BABE, "half_setup");
        run_request(2'd2, 32'h0000_0030, 32'h0000_1234, "half");
    endtask

    task automatic test_noop();
        run_request(2'd0, 32'h0000_0044, $urandom, "noop");
        run_request(2'd3, 32'h0000_0044, $urandom, "after_noop");
    endtask

    // start held high: accepts land every third cycle, one write and one done each.
    task automatic test_back_to_back();
        logic o_wr, o_busy, o_done, e_wr, e_busy, e_done;
        logic [31:0] dat;
        dat        = $urandom;
        size       = 2'd1;
        address    = 32'h0000_0050;
        store_data = dat;
        start      = 1'b1;
        @(posedge clk); #1;
        ref_m[8'h50] = dat;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) start = 1'b0;
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                o_wr   = j ? mem_wr_b : mem_wr_a;
                o_busy = j ? busy_b : busy_a;
                o_done = j ? done_b : done_a;
                e_wr   = (k % 3 == 1);
                e_done = (k % 3 == 2);
                e_busy = (k % 3 != 0) && (k < 9);
                n_checks++;
                if ({o_wr, o_done, o_busy} !== {e_wr, e_done, e_busy})
                    $display("FAIL b2b dut%0d cycle %0d: got wr/done/busy=%b expected %b",
                             j, k, {o_wr, o_done, o_busy}, {e_wr, e_done, e_busy});
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] o_addr, o_din;
        logic        o_wr, o_busy, o_done;
        size       = 2'd3;
        address    = 32'h0000_0060;
        store_data = $urandom;
        start      = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            o_addr = j ? mem_addr_b : mem_addr_a;
            o_din  = j ? mem_data_in_b : mem_data_in_a;
            o_wr   = j ? mem_wr_b : mem_wr_a;
            o_busy = j ? busy_b : busy_a;
            o_done = j ? done_b : done_a;
            n_checks++;
            if ({o_addr, o_din, o_wr, o_busy, o_done} !== 67'd0)
                $display("FAIL reset_mid_async dut%0d: got addr=%h din=%h wr=%b busy=%b done=%b expected all 0",
                         j, o_addr, o_din, o_wr, o_busy, o_done);
            else n_pass++;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                o_wr   = j ? mem_wr_b : mem_wr_a;
                o_busy = j ? busy_b : busy_a;
                o_done = j ? done_b : done_a;
                n_checks++;
                if ({o_wr, o_busy, o_done} !== 3'b000)
                    $display("FAIL reset_mid_quiet dut%0d cycle %0d: got wr/busy/done=%b expected 000",
                             j, k, {o_wr, o_busy, o_done});
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        run_request(2'd1, 32'h0000_0070, $urandom, "post_reset_word");
        run_request(2'd2, 32'h0000_0060, $urandom, "post_reset_half");
    endtask

    task automatic test_stability();
        run_request(2'd2, 32'h0000_0030, 32'h0000_ABCD, "stability_half");
        run_request(2'd3, 32'h0000_0030, 32'h1234_5678, "stability_byte");
    endtask

    task automatic test_random();
        logic [31:0] adr;
        for (int n = 0; n < 40; n++) begin
            adr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
            run_request(2'($urandom), adr, $urandom, "random");
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        size       = 2'd0;
        address    = 32'h0;
        store_data = 32'h0;
        fill_en    = 1'b1;
        for (int i = 0; i < 256; i++) ref_m[i] = init_word(i);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_noop();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
